// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-bit 1-to-8 demultiplexer.
package demux_pkg;

  localparam int DEMUX_NUM_OUT = 8;
  localparam int DEMUX_SEL_W   = 3;

  typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;

endpackage

// File: rtl/dec_3to8.sv
// 3-to-8 one-hot decoder: bit N of onehot is set exactly when sel == N.
module dec_3to8
  import demux_pkg::*;
(
  input  demux_sel_t                 sel,
  output logic [DEMUX_NUM_OUT-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEMUX_NUM_OUT; i++) begin
      if (sel == demux_sel_t'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1b_1to8.sv
// 1-bit 1-to-8 demultiplexer; combinational by default, registered outputs
// with async active-low reset when DEMUX_1B_1TO8_OUT_REG_EN is defined.
module demux_1b_1to8
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_,
  input  demux_sel_t sel,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       out4,
  output logic       out5,
  output logic       out6,
  output logic       out7
);

  logic [DEMUX_NUM_OUT-1:0] onehot;
  logic [DEMUX_NUM_OUT-1:0] steer;
  logic [DEMUX_NUM_OUT-1:0] out_vec;

  dec_3to8 u_dec (
    .sel    (sel),
    .onehot (onehot)
  );

  // Gating the one-hot select with in_ keeps the at-most-one-high invariant.
  assign steer = onehot & {DEMUX_NUM_OUT{in_}};

`ifdef DEMUX_1B_1TO8_OUT_REG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_vec <= '0;
    else        out_vec <= steer;
  end
`else
  // clk and reset stay on the port list so both builds share one interface.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
  assign out_vec = steer;
`endif

  assign out0 = out_vec[0];
  assign out1 = out_vec[1];
  assign out2 = out_vec[2];
  assign out3 = out_vec[3];
  assign out4 = out_vec[4];
  assign out5 = out_vec[5];
  assign out6 = out_vec[6];
  assign out7 = out_vec[7];

endmodule

// File: tb/tb_demux_1b_1to8.sv
// Self-checking bench for demux_1b_1to8 (covers DEMUX_1B_1TO8_OUT_REG_EN when defined).
module tb_demux_1b_1to8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       in_   = 1'b0;
  logic [2:0] sel   = 3'd0;
  logic       out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0] outs;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  demux_1b_1to8 dut (
    .clk   (clk),
    .reset (reset),
    .in_   (in_),
    .sel   (sel),
    .out0  (out0),
    .out1  (out1),
    .out2  (out2),
    .out3  (out3),
    .out4  (out4),
    .out5  (out5),
    .out6  (out6),
    .out7  (out7)
  );

  assign outs = {out7, out6, out5, out4, out3, out2, out1, out0};

  // reference model: the input bit lands at bit position sel, nothing else set
  function automatic logic [7:0] model(input logic b, input int s);
    int v;
    v = b ? (1 << s) : 0;
    return 8'(v);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, compare after the design's latency
  task automatic apply(input string tag, input logic b, input logic [2:0] s);
    logic [7:0] exp;
    @(negedge clk);
    in_ = b;
    sel = s;
    exp_q.push_back(model(b, int'(s)));
`ifdef DEMUX_1B_1TO8_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
    exp = exp_q.pop_front();
    check(tag, outs, exp);
    check({tag, "_max1"}, 8'($countones(outs) <= 1), 8'd1);
  endtask

  initial begin
    // reset state: reset held low while a nonzero vector is presented
    in_ = 1'b1;
    sel = 3'd4;
    #12;
`ifdef DEMUX_1B_1TO8_OUT_REG_EN
    check("reset_state", outs, 8'h00);
`else
    check("reset_state", outs, 8'h10);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int s = 0; s < 8; s++) apply("sweep_in0", 1'b0, 3'(s));
    for (int s = 0; s < 8; s++) apply("sweep_in1", 1'b1, 3'(s));

    apply("hold3_in0", 1'b0, 3'd3);
    apply("hold3_in1", 1'b1, 3'd3);
    apply("hold3_in0b", 1'b0, 3'd3);

    apply("step_sel7", 1'b1, 3'd7);
    apply("step_sel0", 1'b1, 3'd0);

`ifdef DEMUX_1B_1TO8_OUT_REG_EN
    // asynchronous reset mid-cycle clears outputs without a clock edge
    apply("reg_sel6", 1'b1, 3'd6);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", outs, 8'h00);
    // release with in_=1 sel=2: nothing captured until the next rising edge
    @(negedge clk);
    in_   = 1'b1;
    sel   = 3'd2;
    reset = 1'b1;
    #1;
    check("release_hold", outs, 8'h00);
    @(posedge clk);
    #1;
    check("release_capture", outs, model(1'b1, 2));
`else
    // reset and clock have no effect in the combinational build
    @(negedge clk);
    reset = 1'b0;
    apply("reset_ignored_a", 1'b1, 3'd6);
    apply("reset_ignored_b", 1'b1, 3'd1);
    @(negedge clk);
    reset = 1'b1;
`endif

    for (int i = 0; i < 200; i++) begin
      apply("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // bound the run in case a wait never returns
  initial begin
    #100000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
